// File: rtl/seq_det_pkg.sv
// Shared types and limits for the serial pattern detector.
package seq_det_pkg;

  typedef enum logic {
    MODE_FRAMED  = 1'b0,
    MODE_SLIDING = 1'b1
  } seq_mode_e;

  localparam int unsigned SEQ_W_MAX = 32;

endpackage

// File: rtl/seq_det_sat_cnt.sv
// Saturating up-counter; clear wins over increment, holds at all-ones.
module seq_det_sat_cnt #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/param_sequence_detect.sv
// Serial pattern detector with framed and sliding compare modes.
// Define SEQ_DET_CNT_EN to build the saturating hit/miss counters.
module param_sequence_detect
  import seq_det_pkg::*;
#(
  parameter int unsigned SEQ_W = 6,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data_valid,
  input  logic             data,
  input  logic             mode,
  input  logic [SEQ_W-1:0] cfg_pattern,
  input  logic             cnt_clr,
  output logic             match,
  output logic             not_match,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int unsigned BC_W = (SEQ_W > 1) ? $clog2(SEQ_W) : 1;
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(SEQ_W - 1);

  logic [SEQ_W-1:0] sr, sr_d, sr_next;
  logic [BC_W-1:0]  bit_cnt, bit_cnt_d;
  logic [BC_W-1:0]  fill, fill_d;
  seq_mode_e        mode_q, mode_in;
  logic             match_d, not_match_d;
  logic             hit;

  assign mode_in = seq_mode_e'(mode);
  assign sr_next = {sr[SEQ_W-2:0], data};
  assign hit     = (sr_next == cfg_pattern);

  // A mode change restarts framing/fill; that cycle's bit is shifted but not counted.
  always_comb begin
    sr_d        = sr;
    bit_cnt_d   = bit_cnt;
    fill_d      = fill;
    match_d     = 1'b0;
    not_match_d = 1'b0;
    if (data_valid) begin
      sr_d = sr_next;
    end
    if (mode_in != mode_q) begin
      bit_cnt_d = '0;
      fill_d    = '0;
    end else if (data_valid) begin
      if (mode_q == MODE_FRAMED) begin
        if (bit_cnt == LAST_BIT) begin
          bit_cnt_d   = '0;
          match_d     = hit;
          not_match_d = ~hit;
        end else begin
          bit_cnt_d = bit_cnt + BC_W'(1);
        end
      end else begin
        if (fill == LAST_BIT) begin
          match_d = hit;
        end else begin
          fill_d = fill + BC_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr        <= '0;
      bit_cnt   <= '0;
      fill      <= '0;
      mode_q    <= mode_in;
      match     <= 1'b0;
      not_match <= 1'b0;
    end else begin
      sr        <= sr_d;
      bit_cnt   <= bit_cnt_d;
      fill      <= fill_d;
      mode_q    <= mode_in;
      match     <= match_d;
      not_match <= not_match_d;
    end
  end

`ifdef SEQ_DET_CNT_EN
  seq_det_sat_cnt #(.CNT_W(CNT_W)) u_hit_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (match),
    .cnt (hit_cnt)
  );

  seq_det_sat_cnt #(.CNT_W(CNT_W)) u_miss_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (not_match),
    .cnt (miss_cnt)
  );
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign hit_cnt        = '0;
  assign miss_cnt       = '0;
`endif

endmodule
